// File: rtl/mem_access_engine.sv
// ---------------------------------------------------------------------------
// mem_access_engine
//
// Downstream stage of a 3-requestor round-robin arbiter. On a one-hot grant
// seen while idle, the engine latches the owning requestor's command, drives
// one access onto a single-port synchronous SRAM (fixed read latency), then
// returns a single-cycle done pulse (and, for reads, the captured data) to
// that requestor. One access is in flight at a time; grants that arrive while
// the engine is busy are ignored.
//
// Parameters
//   AW        memory address width
//   DW        memory data width
//   RD_LAT    cycles from a read mem_en to valid mem_rdata (1..15)
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   grant      in   one-hot grant from the (registered) arbiter
//   req_addr   in   requestor addresses, requestor i at [i*AW +: AW]
//   req_wdata  in   requestor write data, requestor i at [i*DW +: DW]
//   req_we     in   per-requestor write enable (1 = write, 0 = read)
//   mem_en     out  SRAM access strobe, one cycle per access
//   mem_we     out  SRAM write enable, meaningful only with mem_en
//   mem_addr   out  SRAM address (holds last value when mem_en = 0)
//   mem_wdata  out  SRAM write data (holds last value when mem_en = 0)
//   mem_rdata  in   SRAM read data, valid RD_LAT cycles after a read mem_en
//   done       out  one-hot completion pulse to the owning requestor
//   rdata      out  last read data captured from the SRAM
//   busy       out  high whenever the engine is not idle
//   err        out  one-cycle pulse after a multi-hot grant seen while idle
// ---------------------------------------------------------------------------
module mem_access_engine #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      grant,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*DW-1:0] req_wdata,
    input  logic [2:0]      req_we,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [2:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic            err
);

    localparam int CW = 4;  // wide enough for RD_LAT-1 up to 14

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]      done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    // -----------------------------------------------------------------------
    // Grant decode: exactly one bit set selects a requestor; anything else
    // with at least one bit set is a protocol error.
    // -----------------------------------------------------------------------
    logic            grant_onehot;
    logic [1:0]      grant_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant_onehot = 1'b1;
        grant_idx    = 2'd0;
        case (grant)
            3'b001:  grant_idx = 2'd0;
            3'b010:  grant_idx = 2'd1;
            3'b100:  grant_idx = 2'd2;
            default: grant_onehot = 1'b0;
        endcase
    end

    always_comb begin
        sel_addr  = req_addr[0 +: AW];
        sel_wdata = req_wdata[0 +: DW];
        sel_we    = req_we[0];
        case (grant_idx)
            2'd1: begin
                sel_addr  = req_addr[AW +: AW];
                sel_wdata = req_wdata[DW +: DW];
                sel_we    = req_we[1];
            end
            2'd2: begin
                sel_addr  = req_addr[2*AW +: AW];
                sel_wdata = req_wdata[2*DW +: DW];
                sel_we    = req_we[2];
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic.
    // The latched command lives directly in mem_addr/mem_wdata/mem_we: they
    // are loaded when the grant is accepted and simply hold afterwards, which
    // is also what makes the engine immune to later requestor changes.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 3'b000;
        rdata_d     = rdata_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_onehot) begin
                    idx_d       = grant_idx;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we;
                    mem_en_d    = 1'b1;
                    state_d     = S_ISSUE;
                end else if (grant != 3'b000) begin
                    err_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (mem_we_q) begin
                    done_d  = 3'b001 << idx_q;
                    state_d = S_RESP;
                end else begin
                    // Counting RD_LAT-1 down to 0 makes WAIT last RD_LAT
                    // cycles, so the capture edge lines up with mem_rdata.
                    cnt_d   = CW'(RD_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    done_d  = 3'b001 << idx_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_GAP;
            end
            // GAP swallows the stale grant the registered arbiter still
            // shows while the finished requestor drops its request.
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 3'b000;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_engine.sv
// ---------------------------------------------------------------------------
// tb_mem_access_engine
//
// Bench for mem_access_engine. A behavioural SRAM with RD_LAT pipeline feeds
// mem_rdata. A timeline model predicts, per cycle, every DUT output from the
// accept rules (accept at cycle k -> issue at k+1, done at k+2[+RD_LAT], next
// accept from k+4[+RD_LAT]); one negedge process compares all outputs every
// cycle and also evaluates hand-computed literal expectations queued by the
// stimulus process.
// ---------------------------------------------------------------------------
module tb_mem_access_engine;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;
    localparam int RING   = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      grant;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]      req_we;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic [2:0]      done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    mem_access_engine #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err)
    );

    // Power-up memory content for any address not yet written.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // ------------------------------------------------------------------ SRAM
    logic [DW-1:0] sram    [256];
    bit            written [256];
    logic [DW-1:0] pipe    [RD_LAT];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                sram[mem_addr]    <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                pipe[0] <= written[mem_addr] ? sram[mem_addr] : init_val(mem_addr);
            end
        end
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata = pipe[RD_LAT-1];

    // ------------------------------------------------- literal expectations
    typedef enum int {SIG_EN, SIG_WE, SIG_ADDR, SIG_WDATA, SIG_DONE, SIG_RDATA, SIG_BUSY, SIG_ERR} sig_e;
    typedef struct {
        int          at;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } lit_t;

    lit_t lits[$];
    int   cyc      = 0;   // cycle index, advanced by the compare process
    int   final_at = -1;  // cycle at which the end-of-run checks are made
    int   checks   = 0;
    int   errors   = 0;

    function automatic logic [31:0] dut_sig(input sig_e s);
        case (s)
            SIG_EN:    return 32'(mem_en);
            SIG_WE:    return 32'(mem_we);
            SIG_ADDR:  return 32'(mem_addr);
            SIG_WDATA: return 32'(mem_wdata);
            SIG_DONE:  return 32'(done);
            SIG_RDATA: return 32'(rdata);
            SIG_BUSY:  return 32'(busy);
            default:   return 32'(err);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------- timeline model
    bit              slot_issue [RING];
    logic            slot_we    [RING];
    logic [AW-1:0]   slot_addr  [RING];
    logic [DW-1:0]   slot_wdata [RING];
    logic [2:0]      slot_done  [RING];
    bit              slot_rd    [RING];
    logic [DW-1:0]   slot_rdval [RING];
    bit              slot_busy  [RING];
    bit              slot_err   [RING];

    logic [DW-1:0]   ref_mem [int];
    logic            h_we;
    logic [AW-1:0]   h_addr;
    logic [DW-1:0]   h_wdata;
    logic [DW-1:0]   h_rdata;
    int              free_cyc;
    int              served [3];
    int              s, lat, gi;
    logic [AW-1:0]   a;
    logic [DW-1:0]   w;

    always @(negedge clk) begin
        s = cyc % RING;
        if (reset) begin
            for (int i = 0; i < RING; i++) begin
                slot_issue[i] = 1'b0;
                slot_done[i]  = 3'b000;
                slot_rd[i]    = 1'b0;
                slot_busy[i]  = 1'b0;
                slot_err[i]   = 1'b0;
            end
            h_we     = 1'b0;
            h_addr   = '0;
            h_wdata  = '0;
            h_rdata  = '0;
            free_cyc = 0;
        end else begin
            if (slot_issue[s]) begin
                h_we    = slot_we[s];
                h_addr  = slot_addr[s];
                h_wdata = slot_wdata[s];
            end
            if (slot_rd[s]) h_rdata = slot_rdval[s];
        end

        check("mem_en",    32'(mem_en),    32'(slot_issue[s]));
        check("mem_we",    32'(mem_we),    32'(h_we));
        check("mem_addr",  32'(mem_addr),  32'(h_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(h_wdata));
        check("done",      32'(done),      32'(slot_done[s]));
        check("rdata",     32'(rdata),     32'(h_rdata));
        check("busy",      32'(busy),      32'(slot_busy[s]));
        check("err",       32'(err),       32'(slot_err[s]));

        foreach (lits[i])
            if (lits[i].at == cyc) check(lits[i].name, dut_sig(lits[i].sig), lits[i].val);

        for (int i = 0; i < 3; i++) if (!reset && done[i]) served[i]++;
        if (cyc == final_at)
            for (int i = 0; i < 3; i++) check($sformatf("served_req%0d", i), 32'(served[i] >= 5), 32'd1);

        slot_issue[s] = 1'b0;
        slot_done[s]  = 3'b000;
        slot_rd[s]    = 1'b0;
        slot_busy[s]  = 1'b0;
        slot_err[s]   = 1'b0;

        // Accept rule: engine is idle from free_cyc on; it takes a one-hot
        // grant, flags a multi-hot one, and ignores everything while busy.
        if (!reset && cyc >= free_cyc) begin
            if ($onehot(grant)) begin
                gi = 0;
                for (int i = 0; i < 3; i++) if (grant[i]) gi = i;
                a   = req_addr[gi*AW +: AW];
                w   = req_wdata[gi*DW +: DW];
                lat = req_we[gi] ? 0 : RD_LAT;
                slot_issue[(cyc+1) % RING] = 1'b1;
                slot_we[(cyc+1) % RING]    = req_we[gi];
                slot_addr[(cyc+1) % RING]  = a;
                slot_wdata[(cyc+1) % RING] = w;
                if (req_we[gi]) begin
                    ref_mem[int'(a)] = w;
                end else begin
                    slot_rd[(cyc+2+lat) % RING]    = 1'b1;
                    slot_rdval[(cyc+2+lat) % RING] = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
                end
                slot_done[(cyc+2+lat) % RING] = grant;
                for (int j = 1; j <= 3 + lat; j++) slot_busy[(cyc+j) % RING] = 1'b1;
                free_cyc = cyc + 4 + lat;
            end else if (grant != 3'b000) begin
                slot_err[(cyc+1) % RING] = 1'b1;
            end
        end
        cyc++;
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int off, input sig_e sig, input logic [31:0] val, input string name);
        lits.push_back('{at: cyc + off, sig: sig, val: val, name: name});
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic we);
        req_addr[i*AW +: AW]  = ad;
        req_wdata[i*DW +: DW] = wd;
        req_we[i]             = we;
    endtask

    logic [2:0] req_v;
    logic [2:0] done_seen;
    logic [2:0] g;
    int         owner;
    bit         found;

    initial begin
        reset     = 1'b1;
        grant     = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        req_we    = 3'b000;

        // Reset state
        tick();
        expect_at(0, SIG_EN,    0, "rst_mem_en");
        expect_at(0, SIG_DONE,  0, "rst_done");
        expect_at(0, SIG_RDATA, 0, "rst_rdata");
        expect_at(0, SIG_BUSY,  0, "rst_busy");
        expect_at(0, SIG_ERR,   0, "rst_err");
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();

        // 1: write from requestor 0
        set_req(0, 8'h10, 16'hBEEF, 1'b1);
        grant = 3'b001;
        expect_at(1, SIG_EN,    1,        "t1_mem_en");
        expect_at(1, SIG_WE,    1,        "t1_mem_we");
        expect_at(1, SIG_ADDR,  'h10,     "t1_mem_addr");
        expect_at(1, SIG_WDATA, 'hBEEF,   "t1_mem_wdata");
        expect_at(2, SIG_DONE,  'b001,    "t1_done");
        expect_at(3, SIG_BUSY,  1,        "t1_busy_gap");
        expect_at(4, SIG_BUSY,  0,        "t1_busy_idle");
        tick();
        grant = 3'b000;
        repeat (4) tick();

        // 2: read from requestor 2 of the word just written
        set_req(2, 8'h10, 16'h0000, 1'b0);
        grant = 3'b100;
        expect_at(1, SIG_EN,    1,      "t2_mem_en");
        expect_at(1, SIG_WE,    0,      "t2_mem_we");
        expect_at(3, SIG_DONE,  0,      "t2_no_early_done");
        expect_at(4, SIG_DONE,  'b100,  "t2_done");
        expect_at(4, SIG_RDATA, 'hBEEF, "t2_rdata");
        expect_at(7, SIG_RDATA, 'hBEEF, "t2_rdata_held");
        tick();
        grant = 3'b000;
        repeat (7) tick();

        // 3: grants pulsed while busy are ignored
        set_req(0, 8'h20, 16'h0000, 1'b0);
        set_req(1, 8'h30, 16'h1234, 1'b1);
        grant = 3'b001;
        expect_at(1, SIG_BUSY,  1,       "t3_busy_issue");
        expect_at(3, SIG_EN,    0,       "t3_no_issue_wait");
        expect_at(4, SIG_DONE,  'b001,   "t3_done");
        expect_at(4, SIG_RDATA, 'hDF20,  "t3_rdata");
        expect_at(5, SIG_BUSY,  1,       "t3_busy_gap");
        expect_at(6, SIG_BUSY,  0,       "t3_busy_idle");
        expect_at(6, SIG_EN,    0,       "t3_no_issue_gap");
        expect_at(7, SIG_EN,    0,       "t3_no_issue_after");
        tick(); grant = 3'b000;
        tick(); grant = 3'b010;
        tick(); grant = 3'b010;
        tick(); grant = 3'b000;
        tick(); grant = 3'b010;
        tick(); grant = 3'b000;
        repeat (3) tick();

        // 4: multi-hot grants in IDLE
        grant = 3'b011;
        expect_at(1, SIG_ERR,  1, "t4_err");
        expect_at(1, SIG_EN,   0, "t4_no_issue");
        expect_at(1, SIG_BUSY, 0, "t4_stay_idle");
        expect_at(2, SIG_ERR,  0, "t4_err_pulse");
        tick();
        grant = 3'b000;
        repeat (3) tick();
        grant = 3'b111;
        expect_at(1, SIG_ERR, 1, "t4_err_111a");
        expect_at(2, SIG_ERR, 1, "t4_err_111b");
        expect_at(3, SIG_ERR, 0, "t4_err_clear");
        tick();
        tick();
        grant = 3'b000;
        repeat (3) tick();

        // 5: reset in the middle of a read
        set_req(0, 8'h10, 16'h0000, 1'b0);
        grant = 3'b001;
        tick();
        grant = 3'b000;
        tick();
        reset = 1'b1;
        expect_at(0, SIG_EN,    0, "t5_rst_mem_en");
        expect_at(0, SIG_ADDR,  0, "t5_rst_mem_addr");
        expect_at(0, SIG_RDATA, 0, "t5_rst_rdata");
        expect_at(0, SIG_BUSY,  0, "t5_rst_busy");
        expect_at(2, SIG_DONE,  0, "t5_no_done");
        tick();
        tick();
        reset = 1'b0;
        repeat (2) tick();
        grant = 3'b001;
        expect_at(1, SIG_ADDR,  'h10,   "t5_re_addr");
        expect_at(4, SIG_DONE,  'b001,  "t5_re_done");
        expect_at(4, SIG_RDATA, 'hBEEF, "t5_re_rdata");
        tick();
        grant = 3'b000;
        repeat (6) tick();

        // 6: soak against a registered round-robin arbiter
        req_v = 3'b000;
        owner = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            done_seen = done;
            tick();
            g = 3'b000;
            if (req_v[owner]) begin
                g[owner] = 1'b1;
            end else begin
                found = 1'b0;
                for (int j = 1; j <= 3; j++) begin
                    if (!found && req_v[(owner + j) % 3]) begin
                        owner = (owner + j) % 3;
                        g[owner] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (done_seen[i]) begin
                    req_v[i] = 1'b0;
                end else if (!req_v[i] && $urandom_range(0, 3) == 0) begin
                    req_v[i] = 1'b1;
                    set_req(i, 8'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
                end
            end
            grant = g;
        end
        grant = 3'b000;
        repeat (30) tick();

        final_at = cyc + 1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
